// File: rtl/td4_pkg.sv
// Shared TD4 definitions: FSM encoding, ALU op codes and default datapath width.
package td4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   TD4_WIDTH = 4;

    // Bit counter width: clog2 of the operand width, never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_addr.sv
// Single-bit full adder cell shared by the TD4 serial ALU.
module full_addr (
    input  logic a,
    input  logic b,
    input  logic c0,
    output logic s,
    output logic c1
);

    assign s  = a ^ b ^ c0;
    assign c1 = (a & b) | (c0 & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: runs one full_addr cell over WIDTH cycles,
// LSB first, behind a start/busy/done handshake.
module serial_add_ctrl
    import td4_pkg::*;
#(
    parameter int WIDTH = TD4_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;
    logic             is_sub;

    full_addr u_full_addr (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c0 (carry),
        .s  (bit_s),
        .c1 (bit_c)
    );

    assign is_sub   = (sub == OP_SUB);
    assign res_next = {bit_s, res[WIDTH-1:1]};

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                last_bit = (cnt == LAST_CNT);
                if (last_bit) state_next = ST_DONE;
            end
            ST_DONE: begin
                // A start in the done cycle chains straight into the next op.
                accept     = start;
                state_next = start ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                // Subtraction is a + ~b + 1; the incoming cin is ignored.
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{is_sub}};
                carry <= is_sub ? 1'b1 : cin;
                cnt   <= '0;
                res   <= '0;
            end else if (state == ST_SHIFT) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                res   <= res_next;
                carry <= bit_c;
                cnt   <= cnt + CNT_W'(1);
                if (last_bit) begin
                    sum  <= res_next;
                    cout <= bit_c;
                    zero <= (res_next == '0);
                end
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;
    import td4_pkg::*;

    localparam int W      = 4;
    localparam int PERIOD = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_zero;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    // Reference: plain integer arithmetic, borrow shown as cout=0.
    function automatic void model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                  input logic sub_v, input logic cin_v,
                                  output logic [W-1:0] s_e, output logic c_e);
        int av;
        int bv;
        int t;
        av = int'(a_v);
        bv = int'(b_v);
        if (sub_v == OP_SUB) begin
            t   = av - bv + (1 << W);
            s_e = W'(t % (1 << W));
            c_e = (av >= bv);
        end else begin
            t   = av + bv + int'(cin_v);
            s_e = W'(t % (1 << W));
            c_e = (t >= (1 << W));
        end
    endfunction

    // Starts an op at the current negedge and returns at the negedge where done is seen.
    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic sub_v, input logic cin_v, input bit glitch,
                         input string tag);
        logic [W-1:0] es;
        logic         ec;
        int           busy_cycles;
        bit           seen;
        model(a_v, b_v, sub_v, cin_v, es, ec);
        a = a_v; b = b_v; sub = sub_v; cin = cin_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                checks++;
                if (sum !== held_sum || cout !== held_cout || zero !== held_zero) begin
                    failures++;
                    $display("FAIL %s held_during_shift got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                             tag, sum, cout, zero, held_sum, held_cout, held_zero);
                end
                if (glitch && k == 1) begin
                    start = 1'b1; a = ~a_v; b = b_v + W'(1); sub = ~sub_v; cin = ~cin_v;
                end else if (glitch && k == 2) begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout got=no_done exp=done", tag);
        end
        checks++;
        if (busy_cycles != W) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_cycles, W);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_with_done got=%0b exp=0", tag, busy);
        end
        checks++;
        if (sum !== es || cout !== ec || zero !== (es == '0)) begin
            failures++;
            $display("FAIL %s result got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                     tag, sum, cout, zero, es, ec, (es == '0));
        end
        held_sum  = es;
        held_cout = ec;
        held_zero = (es == '0);
    endtask

    // From the done negedge with no new start: done must drop, result must hold.
    task automatic finish_op(input string tag);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done got=busy%0b/done%0b exp=busy0/done0", tag, busy, done);
        end
        checks++;
        if (sum !== held_sum || cout !== held_cout || zero !== held_zero) begin
            failures++;
            $display("FAIL %s hold_after_done got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                     tag, sum, cout, zero, held_sum, held_cout, held_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = OP_ADD; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, zero} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, sum, cout, zero});
        end
        rst_n     = 1'b1;
        held_sum  = '0;
        held_cout = 1'b0;
        held_zero = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_add();
        do_op(4'd3, 4'd5, OP_ADD, 1'b0, 1'b0, "add_3_5");   finish_op("add_3_5");
        do_op(4'd15, 4'd1, OP_ADD, 1'b0, 1'b0, "add_15_1"); finish_op("add_15_1");
        do_op(4'd7, 4'd7, OP_ADD, 1'b1, 1'b0, "add_7_7_c"); finish_op("add_7_7_c");
    endtask

    task automatic test_sub();
        do_op(4'd5, 4'd3, OP_SUB, 1'b0, 1'b0, "sub_5_3");   finish_op("sub_5_3");
        do_op(4'd3, 4'd5, OP_SUB, 1'b0, 1'b0, "sub_3_5");   finish_op("sub_3_5");
        do_op(4'd3, 4'd5, OP_SUB, 1'b1, 1'b0, "sub_3_5_c"); finish_op("sub_3_5_c");
        do_op(4'd5, 4'd3, OP_SUB, 1'b1, 1'b0, "sub_5_3_c"); finish_op("sub_5_3_c");
    endtask

    task automatic test_start_ignored();
        do_op(4'd9, 4'd4, OP_ADD, 1'b1, 1'b1, "mid_start"); finish_op("mid_start");
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        do_op(4'd12, 4'd6, OP_ADD, 1'b0, 1'b0, "b2b_first");
        t0 = $time;
        do_op(4'd2, 4'd9, OP_SUB, 1'b0, 1'b0, "b2b_second");
        t1 = $time;
        checks++;
        if ((t1 - t0) != time'((W + 1) * PERIOD)) begin
            failures++;
            $display("FAIL b2b_spacing got=%0t exp=%0d", t1 - t0, (W + 1) * PERIOD);
        end
        finish_op("b2b_second");
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        a = 4'd6; b = 4'd2; sub = OP_ADD; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, sum, cout, zero} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b exp=0", {busy, done, sum, cout, zero});
        end
        held_sum  = '0;
        held_cout = 1'b0;
        held_zero = 1'b0;
        saw_done  = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_abandon got=activity exp=idle");
        end
        do_op(4'd10, 4'd5, OP_ADD, 1'b0, 1'b0, "after_reset"); finish_op("after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;
        bit           rg;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rg = ($urandom_range(0, 3) == 0);
            do_op(ra, rb, rs, rc, rg, "random");
            if ($urandom_range(0, 1) == 1) finish_op("random");
        end
        finish_op("random_end");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
